// File: rtl/rc4_pkg.sv
// Shared types for the RC4 decoder: S-memory ownership codes, sequencer states
// and small state-decoding helpers.
package rc4_pkg;

  localparam int S_DEPTH = 256;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INIT = 2'd1,
    OWN_SHUF = 2'd2,
    OWN_DEC  = 2'd3
  } owner_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_START,
    ST_INIT_RUN,
    ST_SHUF_START,
    ST_SHUF_RUN,
    ST_DEC_START,
    ST_DEC_RUN,
    ST_STOP,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  function automatic owner_t state_owner(input seq_state_t s);
    owner_t o;
    case (s)
      ST_INIT_START, ST_INIT_RUN: o = OWN_INIT;
      ST_SHUF_START, ST_SHUF_RUN: o = OWN_SHUF;
      ST_DEC_START,  ST_DEC_RUN:  o = OWN_DEC;
      default:                    o = OWN_NONE;
    endcase
    return o;
  endfunction

  function automatic logic is_start(input seq_state_t s);
    return (s == ST_INIT_START) || (s == ST_SHUF_START) || (s == ST_DEC_START);
  endfunction

  function automatic logic is_run(input seq_state_t s);
    return (s == ST_INIT_RUN) || (s == ST_SHUF_RUN) || (s == ST_DEC_RUN);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Saturating per-phase cycle counter; flags expiry on the RUN cycle in which the
// count reaches TIMEOUT-1, so a phase gets at most TIMEOUT-1 RUN cycles.
module phase_watchdog #(
  parameter int TIMEOUT = 4096,
  parameter int WDOG_W  = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 2);

  logic [WDOG_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q == LIMIT means this RUN cycle brings the count to TIMEOUT-1
  assign expired = enable && !clear && (count_q >= LIMIT);

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Runs S-init, shuffle and decrypt in order and grants the single S-memory port
// to exactly one phase FSM at a time, with watchdog and abort handling.
module rc4_phase_sequencer
  import rc4_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4096,
  parameter int WDOG_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              init_start,
  output logic              shuf_start,
  output logic              dec_start,
  input  logic              init_done,
  input  logic              shuf_done,
  input  logic              dec_done,
  output logic              shuf_stop,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] shuf_addr,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [DATA_W-1:0] shuf_data,
  input  logic [DATA_W-1:0] dec_data,
  input  logic              init_wren,
  input  logic              shuf_wren,
  input  logic              dec_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic [1:0]        owner,
  output logic              busy,
  output logic              done,
  output logic              error
);

  seq_state_t state_q, state_d;
  owner_t     owner_q, owner_d;
  logic init_start_q, init_start_d;
  logic shuf_start_q, shuf_start_d;
  logic dec_start_q,  dec_start_d;
  logic shuf_stop_q,  shuf_stop_d;
  logic busy_q,  busy_d;
  logic done_q,  done_d;
  logic error_q, error_d;
  logic wd_expired;

  phase_watchdog #(
    .TIMEOUT(TIMEOUT),
    .WDOG_W (WDOG_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (is_start(state_q)),
    .enable (is_run(state_q)),
    .expired(wd_expired)
  );

  // Priority inside a RUN state: abort, then the phase's own done, then watchdog
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start && !abort) state_d = ST_INIT_START;
      ST_INIT_START: state_d = abort ? ST_STOP : ST_INIT_RUN;
      ST_SHUF_START: state_d = abort ? ST_STOP : ST_SHUF_RUN;
      ST_DEC_START:  state_d = abort ? ST_STOP : ST_DEC_RUN;
      ST_INIT_RUN: begin
        if (abort)           state_d = ST_STOP;
        else if (init_done)  state_d = ST_SHUF_START;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_SHUF_RUN: begin
        if (abort)           state_d = ST_STOP;
        else if (shuf_done)  state_d = ST_DEC_START;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_DEC_RUN: begin
        if (abort)           state_d = ST_STOP;
        else if (dec_done)   state_d = ST_DONE;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_STOP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d      = state_owner(state_d);
    init_start_d = (state_d == ST_INIT_START);
    shuf_start_d = (state_d == ST_SHUF_START);
    dec_start_d  = (state_d == ST_DEC_START);
    shuf_stop_d  = (state_d == ST_STOP);
    busy_d       = (owner_d != OWN_NONE);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      init_start_q <= 1'b0;
      shuf_start_q <= 1'b0;
      dec_start_q  <= 1'b0;
      shuf_stop_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      init_start_q <= init_start_d;
      shuf_start_q <= shuf_start_d;
      dec_start_q  <= dec_start_d;
      shuf_stop_q  <= shuf_stop_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Port mux follows the registered grant so requesters see zero extra latency
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    case (owner_q)
      OWN_INIT: begin
        mem_addr = init_addr;
        mem_data = init_data;
        mem_wren = init_wren;
      end
      OWN_SHUF: begin
        mem_addr = shuf_addr;
        mem_data = shuf_data;
        mem_wren = shuf_wren;
      end
      OWN_DEC: begin
        mem_addr = dec_addr;
        mem_data = dec_data;
        mem_wren = dec_wren;
      end
      default: ;
    endcase
  end

  assign owner      = owner_q;
  assign init_start = init_start_q;
  assign shuf_start = shuf_start_q;
  assign dec_start  = dec_start_q;
  assign shuf_stop  = shuf_stop_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Scoreboard bench: stimulus pushes the expected pulse events (kind, cycle, owner),
// a negedge monitor pops and compares them as the sequencers emit pulses.
module tb_rc4_phase_sequencer;

  localparam int EV_INIT = 1;
  localparam int EV_SHUF = 2;
  localparam int EV_DEC  = 3;
  localparam int EV_STOP = 4;
  localparam int EV_DONE = 5;
  localparam int EV_ERR  = 6;

  typedef struct {
    int inst;
    int kind;
    int at;
    int own;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start, abort, init_done, shuf_done, dec_done;
  logic w_start, w_abort, w_init_done, w_shuf_done, w_dec_done;
  logic [7:0] init_addr, shuf_addr, dec_addr, init_data, shuf_data, dec_data;
  logic init_wren, shuf_wren, dec_wren;

  logic init_start, shuf_start, dec_start, shuf_stop, busy, done, error, mem_wren;
  logic [7:0] mem_addr, mem_data;
  logic [1:0] owner;
  logic w_init_start, w_shuf_start, w_dec_start, w_shuf_stop, w_busy, w_done, w_error, w_mem_wren;
  logic [7:0] w_mem_addr, w_mem_data;
  logic [1:0] w_owner;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit prev_dn [0:1];
  bit prev_er [0:1];

  rc4_phase_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
    .init_done(init_done), .shuf_done(shuf_done), .dec_done(dec_done),
    .shuf_stop(shuf_stop),
    .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
    .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
    .init_wren(init_wren), .shuf_wren(shuf_wren), .dec_wren(dec_wren),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .owner(owner), .busy(busy), .done(done), .error(error)
  );

  rc4_phase_sequencer #(.TIMEOUT(16), .WDOG_W(5)) dut_wd (
    .clk(clk), .reset(reset), .start(w_start), .abort(w_abort),
    .init_start(w_init_start), .shuf_start(w_shuf_start), .dec_start(w_dec_start),
    .init_done(w_init_done), .shuf_done(w_shuf_done), .dec_done(w_dec_done),
    .shuf_stop(w_shuf_stop),
    .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
    .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
    .init_wren(init_wren), .shuf_wren(shuf_wren), .dec_wren(dec_wren),
    .mem_addr(w_mem_addr), .mem_data(w_mem_data), .mem_wren(w_mem_wren),
    .owner(w_owner), .busy(w_busy), .done(w_done), .error(w_error)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expectEvent(input int inst, input int kind, input int at, input int own);
    exp_t e;
    e.inst = inst;
    e.kind = kind;
    e.at   = at;
    e.own  = own;
    sb.push_back(e);
  endtask

  task automatic checkOne(input int inst, input int kind, input logic [1:0] own);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_event inst=%0d kind=%0d cycle=%0d, required no event",
               inst, kind, cyc);
    end else begin
      e = sb.pop_front();
      if (e.inst != inst || e.kind != kind || e.at != cyc || e.own != int'(own)) begin
        failures++;
        $display("[TB] FAIL event actual inst=%0d kind=%0d cycle=%0d owner=%0d required inst=%0d kind=%0d cycle=%0d owner=%0d",
                 inst, kind, cyc, own, e.inst, e.kind, e.at, e.own);
      end
    end
  endtask

  task automatic checkOutput(input int inst, input logic is, input logic ss, input logic ds,
                             input logic stp, input logic dn, input logic er,
                             input logic [1:0] own);
    if (is) checkOne(inst, EV_INIT, own);
    if (ss) checkOne(inst, EV_SHUF, own);
    if (ds) checkOne(inst, EV_DEC, own);
    if (stp) checkOne(inst, EV_STOP, own);
    if (dn && !prev_dn[inst]) checkOne(inst, EV_DONE, own);
    if (er && !prev_er[inst]) checkOne(inst, EV_ERR, own);
    prev_dn[inst] = dn;
    prev_er[inst] = er;
  endtask

  // Monitor: every pulse or status rise is matched against the scoreboard
  always @(negedge clk) begin
    checkOutput(0, init_start, shuf_start, dec_start, shuf_stop, done, error, owner);
    checkOutput(1, w_init_start, w_shuf_start, w_dec_start, w_shuf_stop, w_done, w_error, w_owner);
  end

  task automatic applyStimulus(input int inst, input logic s, input logic a,
                               input logic id, input logic sd, input logic dd);
    if (inst == 0) begin
      start = s; abort = a; init_done = id; shuf_done = sd; dec_done = dd;
    end else begin
      w_start = s; w_abort = a; w_init_done = id; w_shuf_done = sd; w_dec_done = dd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkMux(input int own);
    int ea, ed, ew;
    ea = 0; ed = 0; ew = 0;
    case (own)
      1: begin ea = 8'h11; ed = 8'hA1; ew = 1; end
      2: begin ea = 8'h22; ed = 8'hB2; ew = 1; end
      3: begin ea = 8'h33; ed = 8'hC3; ew = 1; end
      default: ;
    endcase
    checkVal("mux_addr", int'(mem_addr), ea);
    checkVal("mux_data", int'(mem_data), ed);
    checkVal("mux_wren", int'(mem_wren), ew);
    if (own != 0) begin
      if (own == 1) init_wren = 1'b0;
      if (own == 2) shuf_wren = 1'b0;
      if (own == 3) dec_wren = 1'b0;
      #1;
      checkVal("mux_wren_owner_low", int'(mem_wren), 0);
      init_wren = 1'b1; shuf_wren = 1'b1; dec_wren = 1'b1;
      #1;
    end
  endtask

  // Drive the main sequencer from IDLE/DONE into the first SHUF_RUN cycle
  task automatic runToShufRun();
    applyStimulus(0, 1, 0, 0, 0, 0);
    expectEvent(0, EV_INIT, cyc + 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    ticks(3);
    applyStimulus(0, 0, 0, 1, 0, 0);
    expectEvent(0, EV_SHUF, cyc + 1, 2);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin : main
    int lens [3];
    int c2;
    lens[0] = 256; lens[1] = 3072; lens[2] = 500;

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    init_addr = 8'h11; init_data = 8'hA1;
    shuf_addr = 8'h22; shuf_data = 8'hB2;
    dec_addr  = 8'h33; dec_data  = 8'hC3;
    init_wren = 1'b1; shuf_wren = 1'b1; dec_wren = 1'b1;
    #1 reset = 1'b0;
    #1;
    checkVal("rst_owner", int'(owner), 0);
    checkVal("rst_status", int'({init_start, shuf_start, dec_start, shuf_stop, busy, done, error}), 0);
    checkVal("rst_mem", int'({mem_addr, mem_data, mem_wren}), 0);
    checkVal("rst_wd_status", int'({w_owner, w_busy, w_done, w_error, w_mem_wren}), 0);
    ticks(2);
    reset = 1'b1;
    tick();

    // Nominal run, stale init_done/shuf_done stay high into later phases
    applyStimulus(0, 1, 0, 0, 0, 0);
    expectEvent(0, EV_INIT, cyc + 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      checkVal("start_owner", int'(owner), p + 1);
      checkVal("start_busy", int'(busy), 1);
      tick();
      checkVal("run_owner", int'(owner), p + 1);
      checkMux(p + 1);
      ticks(lens[p] - 1);
      applyStimulus(0, 0, 0, 1'b1, p >= 1, p >= 2);
      if (p == 2) expectEvent(0, EV_DONE, cyc + 1, 0);
      else        expectEvent(0, p + 2, cyc + 1, p + 2);
      tick();
    end
    checkVal("done_flag", int'(done), 1);
    checkVal("done_owner", int'(owner), 0);
    checkVal("done_busy", int'(busy), 0);
    checkMux(0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkVal("done_start_abort_hold", int'(done), 1);

    // Abort during SHUF_RUN
    runToShufRun();
    ticks(3);
    applyStimulus(0, 0, 1, 0, 0, 0);
    expectEvent(0, EV_STOP, cyc + 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVal("stop_busy", int'(busy), 0);
    tick();
    checkVal("abort_idle", int'({owner, busy, done, error}), 0);
    ticks(20);

    // Start with abort in IDLE stays IDLE
    applyStimulus(0, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkVal("idle_start_abort_busy", int'(busy), 0);

    // Abort wins over a simultaneous shuf_done
    runToShufRun();
    tick();
    applyStimulus(0, 0, 1, 0, 1, 0);
    expectEvent(0, EV_STOP, cyc + 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    ticks(10);

    // Abort during INIT_START
    applyStimulus(0, 1, 0, 0, 0, 0);
    expectEvent(0, EV_INIT, cyc + 1, 1);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 0);
    expectEvent(0, EV_STOP, cyc + 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    ticks(4);

    // Watchdog expiry in SHUF_RUN with TIMEOUT=16, stale init_done held
    applyStimulus(1, 1, 0, 0, 0, 0);
    expectEvent(1, EV_INIT, cyc + 1, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 1, 0, 0);
    expectEvent(1, EV_SHUF, cyc + 1, 2);
    tick();
    c2 = cyc;
    expectEvent(1, EV_ERR, c2 + 16, 0);
    ticks(20);
    checkVal("wd_error", int'(w_error), 1);
    checkVal("wd_error_owner", int'(w_owner), 0);
    checkVal("wd_error_busy", int'(w_busy), 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    expectEvent(1, EV_INIT, cyc + 1, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkVal("wd_restart_error_clr", int'(w_error), 0);

    // Done on the watchdog-expiry cycle takes the next phase
    ticks(15);
    applyStimulus(1, 0, 0, 1, 0, 0);
    expectEvent(1, EV_SHUF, cyc + 1, 2);
    tick();
    ticks(2);
    applyStimulus(1, 0, 0, 1, 1, 0);
    expectEvent(1, EV_DEC, cyc + 1, 3);
    tick();
    ticks(2);
    applyStimulus(1, 0, 0, 1, 1, 1);
    expectEvent(1, EV_DONE, cyc + 1, 0);
    tick();
    tick();
    checkVal("wd_race_done", int'(w_done), 1);
    checkVal("wd_race_no_error", int'(w_error), 0);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-DEC_RUN
    runToShufRun();
    applyStimulus(0, 0, 0, 0, 1, 0);
    expectEvent(0, EV_DEC, cyc + 1, 3);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    ticks(3);
    checkVal("dec_run_owner", int'(owner), 3);
    #1 reset = 1'b0;
    #1;
    checkVal("arst_owner", int'(owner), 0);
    checkVal("arst_status", int'({init_start, shuf_start, dec_start, shuf_stop, busy, done, error}), 0);
    checkVal("arst_mem", int'({mem_addr, mem_data, mem_wren}), 0);
    tick();
    reset = 1'b1;
    ticks(3);
    checkVal("post_reset_busy", int'(busy), 0);

    ticks(5);
    checkVal("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
